// File: rtl/fetch_queue_2way.sv
// Fetch stage behind the instruction cache: drives the fetch PC and splits each 64-bit line
// into one or two 32-bit instructions. These are queued in a circular buffer for decode.
module fetch_queue_2way #(
  parameter int                XLEN     = 32,
  parameter int                FQ_DEPTH = 8,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [63:0]       Icache_data_out,
  input  logic              Icache_valid_out,
  output logic [XLEN-1:0]   proc2Icache_addr,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic [1:0]        dispatch_count,
  output logic [31:0]       inst0,
  output logic [31:0]       inst1,
  output logic [XLEN-1:0]   pc0,
  output logic [XLEN-1:0]   pc1,
  output logic              valid0,
  output logic              valid1,
  output logic              fq_full
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [31:0]      inst_mem [FQ_DEPTH];
  logic [XLEN-1:0]  pc_mem   [FQ_DEPTH];

  logic             pair_fetch;
  logic [CNT_W-1:0] enq_size;
  logic [CNT_W-1:0] free_slots;
  logic             enq;
  logic [CNT_W-1:0] enq_n;
  logic [CNT_W-1:0] req_deq;
  logic [CNT_W-1:0] deq_n;
  logic [PTR_W-1:0] tail_plus1;
  logic [PTR_W-1:0] head_plus1;
  logic [XLEN-1:0]  redirect_target;
  logic [XLEN-1:0]  fetch_pc_next_seq;

  // Write ports: port 0 always targets tail, port 1 (pair fetch only) targets tail+1.
  logic             wr0_en;
  logic [31:0]      wr0_inst;
  logic [XLEN-1:0]  wr0_pc;
  logic             wr1_en;
  logic [31:0]      wr1_inst;
  logic [XLEN-1:0]  wr1_pc;

  assign proc2Icache_addr = fetch_pc;

  // An aligned PC takes both words of the line; a PC at word 1 takes only the upper word.
  assign pair_fetch = ~fetch_pc[2];
  assign enq_size   = pair_fetch ? CNT_W'(2) : CNT_W'(1);
  assign free_slots = DEPTH_C - count;

  // Space check uses the pre-dequeue count; same-cycle dispatch is not credited.
  assign enq   = Icache_valid_out & ~redirect_valid & (free_slots >= enq_size);
  assign enq_n = enq ? enq_size : '0;

  assign req_deq = CNT_W'(dispatch_count);
  assign deq_n   = redirect_valid ? '0 : ((req_deq < count) ? req_deq : count);

  assign tail_plus1 = tail + PTR_W'(1);
  assign head_plus1 = head + PTR_W'(1);

  assign redirect_target   = redirect_pc & ~XLEN'(3);
  assign fetch_pc_next_seq = fetch_pc + (pair_fetch ? XLEN'(8) : XLEN'(4));

  always_comb begin
    wr0_en   = enq & ~reset;
    wr1_en   = enq & ~reset & pair_fetch;
    wr0_inst = pair_fetch ? Icache_data_out[31:0] : Icache_data_out[63:32];
    wr0_pc   = fetch_pc;
    wr1_inst = Icache_data_out[63:32];
    wr1_pc   = fetch_pc + XLEN'(4);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      head  <= head + PTR_W'(deq_n);
      tail  <= tail + PTR_W'(enq_n);
      count <= count + enq_n - deq_n;
      if (enq) begin
        fetch_pc <= fetch_pc_next_seq;
      end
    end
  end

  // Payload storage carries no reset; occupancy is tracked entirely by count.
  always_ff @(posedge clock) begin
    if (wr0_en) begin
      inst_mem[tail] <= wr0_inst;
      pc_mem[tail]   <= wr0_pc;
    end
    if (wr1_en) begin
      inst_mem[tail_plus1] <= wr1_inst;
      pc_mem[tail_plus1]   <= wr1_pc;
    end
  end

  always_comb begin
    valid0  = (count >= CNT_W'(1));
    valid1  = (count >= CNT_W'(2));
    fq_full = (count == DEPTH_C);
    inst0   = valid0 ? inst_mem[head]       : 32'h0;
    pc0     = valid0 ? pc_mem[head]         : '0;
    inst1   = valid1 ? inst_mem[head_plus1] : 32'h0;
    pc1     = valid1 ? pc_mem[head_plus1]   : '0;
  end

endmodule

// File: tb/tb_fetch_queue_2way.sv
// Bench for fetch_queue_2way: hand-derived vector table, then a queue-based reference model
// driven by directed corner sequences and random stimulus.
module tb_fetch_queue_2way;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] Icache_data_out;
  logic        Icache_valid_out;
  logic [31:0] proc2Icache_addr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  dispatch_count;
  logic [31:0] inst0, inst1, pc0, pc1;
  logic        valid0, valid1, fq_full;

  fetch_queue_2way #(.XLEN(32), .FQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock            (clock),
    .reset            (reset),
    .Icache_data_out  (Icache_data_out),
    .Icache_valid_out (Icache_valid_out),
    .proc2Icache_addr (proc2Icache_addr),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .dispatch_count   (dispatch_count),
    .inst0            (inst0),
    .inst1            (inst1),
    .pc0              (pc0),
    .pc1              (pc1),
    .valid0           (valid0),
    .valid1           (valid1),
    .fq_full          (fq_full)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [63:0] d, input logic rd,
                       input logic [31:0] rp, input logic [1:0] dc);
    @(negedge clock);
    reset            = rst;
    Icache_valid_out = v;
    Icache_data_out  = d;
    redirect_valid   = rd;
    redirect_pc      = rp;
    dispatch_count   = dc;
    @(posedge clock);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        valid;
    logic [63:0] data;
    logic        redir;
    logic [31:0] rpc;
    logic [1:0]  disp;
    logic        v0;
    logic        v1;
    logic [31:0] i0;
    logic [31:0] p0;
    logic [31:0] i1;
    logic [31:0] p1;
    logic [31:0] addr;
    logic        full;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vt [NVEC];

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]} ^ 32'h0000_1357;
  endfunction

  function automatic logic [63:0] line_of(input logic [31:0] a);
    return {mem_word({a[31:3], 3'b100}), mem_word({a[31:3], 3'b000})};
  endfunction

  task automatic model_update(input logic rst, input logic v, input logic [63:0] d,
                              input logic rd, input logic [31:0] rp, input logic [1:0] dc);
    int n;
    int dq;
    bit do_enq;
    if (rst) begin
      q.delete();
      m_pc = 32'h0;
    end else if (rd) begin
      q.delete();
      m_pc = {rp[31:2], 2'b00};
    end else begin
      n      = m_pc[2] ? 1 : 2;
      do_enq = v && ((DEPTH - q.size()) >= n);
      dq     = (int'(dc) < q.size()) ? int'(dc) : q.size();
      repeat (dq) void'(q.pop_front());
      if (do_enq) begin
        if (n == 2) begin
          q.push_back('{inst: d[31:0],  pc: m_pc});
          q.push_back('{inst: d[63:32], pc: m_pc + 32'd4});
        end else begin
          q.push_back('{inst: d[63:32], pc: m_pc});
        end
        m_pc = m_pc + 32'(4 * n);
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] e_i0, e_p0, e_i1, e_p1;
    e_i0 = (q.size() >= 1) ? q[0].inst : 32'h0;
    e_p0 = (q.size() >= 1) ? q[0].pc   : 32'h0;
    e_i1 = (q.size() >= 2) ? q[1].inst : 32'h0;
    e_p1 = (q.size() >= 2) ? q[1].pc   : 32'h0;
    chk({tag, ".addr"},   proc2Icache_addr, m_pc);
    chk({tag, ".valid0"}, 32'(valid0), 32'(q.size() >= 1));
    chk({tag, ".valid1"}, 32'(valid1), 32'(q.size() >= 2));
    chk({tag, ".inst0"},  inst0, e_i0);
    chk({tag, ".pc0"},    pc0,   e_p0);
    chk({tag, ".inst1"},  inst1, e_i1);
    chk({tag, ".pc1"},    pc1,   e_p1);
    chk({tag, ".full"},   32'(fq_full), 32'(q.size() == DEPTH));
  endtask

  // One model-tracked cycle; cache data comes from the memory image at the model's fetch PC.
  task automatic step(input string tag, input logic rst, input logic v, input logic rd,
                      input logic [31:0] rp, input logic [1:0] dc);
    logic [63:0] d;
    d = line_of(m_pc);
    drive(rst, v, d, rd, rp, dc);
    model_update(rst, v, d, rd, rp, dc);
    check_model(tag);
  endtask

  initial begin
    logic [31:0] addr_hold;
    logic [31:0] stream_base;

    vt[0]  = '{1'b1, 64'hAAAABBBB_CCCCDDDD, 1'b0, 32'h0,   2'd0, 1'b1, 1'b1, 32'hCCCCDDDD, 32'h000, 32'hAAAABBBB, 32'h004, 32'h008, 1'b0};
    vt[1]  = '{1'b1, 64'h12345678_9ABCDEF0, 1'b1, 32'h106, 2'd0, 1'b0, 1'b0, 32'h0,        32'h000, 32'h0,        32'h000, 32'h104, 1'b0};
    vt[2]  = '{1'b1, 64'h11111111_22222222, 1'b0, 32'h0,   2'd0, 1'b1, 1'b0, 32'h11111111, 32'h104, 32'h0,        32'h000, 32'h108, 1'b0};
    vt[3]  = '{1'b1, 64'h33333333_44444444, 1'b0, 32'h0,   2'd1, 1'b1, 1'b1, 32'h44444444, 32'h108, 32'h33333333, 32'h10C, 32'h110, 1'b0};
    vt[4]  = '{1'b0, 64'h0,                 1'b0, 32'h0,   2'd0, 1'b1, 1'b1, 32'h44444444, 32'h108, 32'h33333333, 32'h10C, 32'h110, 1'b0};
    vt[5]  = '{1'b1, 64'h55555555_66666666, 1'b0, 32'h0,   2'd2, 1'b1, 1'b1, 32'h66666666, 32'h110, 32'h55555555, 32'h114, 32'h118, 1'b0};
    vt[6]  = '{1'b1, 64'h77777777_88888888, 1'b0, 32'h0,   2'd0, 1'b1, 1'b1, 32'h66666666, 32'h110, 32'h55555555, 32'h114, 32'h120, 1'b0};
    vt[7]  = '{1'b1, 64'h99999999_AAAAAAAA, 1'b0, 32'h0,   2'd0, 1'b1, 1'b1, 32'h66666666, 32'h110, 32'h55555555, 32'h114, 32'h128, 1'b0};
    vt[8]  = '{1'b1, 64'hBBBBBBBB_CCCCCCCC, 1'b0, 32'h0,   2'd0, 1'b1, 1'b1, 32'h66666666, 32'h110, 32'h55555555, 32'h114, 32'h130, 1'b1};
    vt[9]  = '{1'b1, 64'hDDDDDDDD_EEEEEEEE, 1'b0, 32'h0,   2'd0, 1'b1, 1'b1, 32'h66666666, 32'h110, 32'h55555555, 32'h114, 32'h130, 1'b1};
    vt[10] = '{1'b1, 64'hDDDDDDDD_EEEEEEEE, 1'b0, 32'h0,   2'd1, 1'b1, 1'b1, 32'h55555555, 32'h114, 32'h88888888, 32'h118, 32'h130, 1'b0};
    vt[11] = '{1'b1, 64'hDDDDDDDD_EEEEEEEE, 1'b0, 32'h0,   2'd0, 1'b1, 1'b1, 32'h55555555, 32'h114, 32'h88888888, 32'h118, 32'h130, 1'b0};
    vt[12] = '{1'b1, 64'hDDDDDDDD_EEEEEEEE, 1'b0, 32'h0,   2'd2, 1'b1, 1'b1, 32'h77777777, 32'h11C, 32'hAAAAAAAA, 32'h120, 32'h130, 1'b0};
    vt[13] = '{1'b1, 64'hDDDDDDDD_EEEEEEEE, 1'b0, 32'h0,   2'd0, 1'b1, 1'b1, 32'h77777777, 32'h11C, 32'hAAAAAAAA, 32'h120, 32'h138, 1'b0};
    vt[14] = '{1'b1, 64'h0BAD0BAD_0BAD0BAD, 1'b1, 32'h203, 2'd2, 1'b0, 1'b0, 32'h0,        32'h000, 32'h0,        32'h000, 32'h200, 1'b0};
    vt[15] = '{1'b0, 64'h0,                 1'b0, 32'h0,   2'd2, 1'b0, 1'b0, 32'h0,        32'h000, 32'h0,        32'h000, 32'h200, 1'b0};
    vt[16] = '{1'b1, 64'h0F0F0F0F_F0F0F0F0, 1'b0, 32'h0,   2'd2, 1'b1, 1'b1, 32'hF0F0F0F0, 32'h200, 32'h0F0F0F0F, 32'h204, 32'h208, 1'b0};
    vt[17] = '{1'b1, 64'h12121212_34343434, 1'b0, 32'h0,   2'd2, 1'b1, 1'b1, 32'h34343434, 32'h208, 32'h12121212, 32'h20C, 32'h210, 1'b0};
    vt[18] = '{1'b0, 64'h0,                 1'b0, 32'h0,   2'd1, 1'b1, 1'b0, 32'h12121212, 32'h20C, 32'h0,        32'h000, 32'h210, 1'b0};
    vt[19] = '{1'b0, 64'h0,                 1'b0, 32'h0,   2'd2, 1'b0, 1'b0, 32'h0,        32'h000, 32'h0,        32'h000, 32'h210, 1'b0};

    reset = 1'b1; Icache_valid_out = 1'b0; Icache_data_out = 64'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; dispatch_count = 2'd0;
    drive(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 2'd0);
    drive(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 2'd0);
    chk("reset.addr",   proc2Icache_addr, 32'h0);
    chk("reset.valid0", 32'(valid0), 32'h0);
    chk("reset.valid1", 32'(valid1), 32'h0);
    chk("reset.full",   32'(fq_full), 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      drive(1'b0, vt[i].valid, vt[i].data, vt[i].redir, vt[i].rpc, vt[i].disp);
      chk($sformatf("vec%0d.valid0", i), 32'(valid0), 32'(vt[i].v0));
      chk($sformatf("vec%0d.valid1", i), 32'(valid1), 32'(vt[i].v1));
      chk($sformatf("vec%0d.inst0", i),  inst0, vt[i].i0);
      chk($sformatf("vec%0d.pc0", i),    pc0,   vt[i].p0);
      chk($sformatf("vec%0d.inst1", i),  inst1, vt[i].i1);
      chk($sformatf("vec%0d.pc1", i),    pc1,   vt[i].p1);
      chk($sformatf("vec%0d.addr", i),   proc2Icache_addr, vt[i].addr);
      chk($sformatf("vec%0d.full", i),   32'(fq_full), 32'(vt[i].full));
    end

    // Reset mid-operation wins over a simultaneous redirect and hit.
    q.delete();
    m_pc = 32'h0;
    step("midreset_fill", 1'b0, 1'b1, 1'b1, 32'h400, 2'd0);
    step("midreset_fill", 1'b0, 1'b1, 1'b0, 32'h0, 2'd0);
    step("midreset", 1'b1, 1'b1, 1'b1, 32'h800, 2'd2);

    // Five miss cycles hold everything; the first hit afterwards enqueues.
    step("miss_fill", 1'b0, 1'b1, 1'b0, 32'h0, 2'd0);
    step("miss_fill", 1'b0, 1'b1, 1'b0, 32'h0, 2'd0);
    addr_hold = proc2Icache_addr;
    for (int i = 0; i < 5; i++) begin
      step("miss", 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
      chk("miss.addr_hold", proc2Icache_addr, addr_hold);
    end
    step("miss_end", 1'b0, 1'b1, 1'b0, 32'h0, 2'd0);

    // Steady stream across the top of the address space.
    stream_base = 32'hFFFF_FF80;
    step("stream_redir", 1'b0, 1'b1, 1'b1, stream_base, 2'd2);
    for (int i = 0; i < 40; i++) begin
      step("stream", 1'b0, 1'b1, 1'b0, 32'h0, 2'd2);
      chk("stream.pc0_seq", pc0, stream_base + 32'(8 * i));
    end

    for (int i = 0; i < 2000; i++) begin
      logic        r_rst, r_v, r_rd;
      logic [31:0] r_pc;
      logic [1:0]  r_dc;
      r_rst = ($urandom_range(0, 199) == 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_rd  = ($urandom_range(0, 19) == 0);
      r_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
      r_dc  = 2'($urandom_range(0, 2));
      step("rand", r_rst, r_v, r_rd, r_pc, r_dc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
